// File: rtl/cnn_io_pkg.sv
// cnn_io_pkg: shared types, sizes and word-ordering helper for the CNN pin loader
package cnn_io_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_PRESENTED
  } bank_state_e;

  localparam int DEF_PIN_W = 12;
  localparam int DEF_WORDS = 200;
  localparam int MEM_W     = DEF_PIN_W * DEF_WORDS;

  // First flat-bus index of word k; the word's pin0 (pins MSB) lands on this index.
  function automatic int word_base(input int k, input int pin_w);
    return k * pin_w;
  endfunction

endpackage

// File: rtl/frame_bank.sv
// frame_bank: one word-addressed frame store with a flat, pin0-first output
module frame_bank
  import cnn_io_pkg::*;
#(
  parameter int PIN_W = DEF_PIN_W,
  parameter int WORDS = DEF_WORDS,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [CNT_W-1:0]       addr,
  input  logic [PIN_W-1:0]       wdata,
  output logic [0:PIN_W*WORDS-1] q
);

  // Contents are don't-care until written, so the store carries no reset.
  always_ff @(posedge clk)
    if (we) q[word_base(int'(addr), PIN_W) +: PIN_W] <= wdata;

endmodule

// File: rtl/frame_pingpong_loader.sv
// frame_pingpong_loader: packs pin words into frames across two ping-pong banks
module frame_pingpong_loader
  import cnn_io_pkg::*;
#(
  parameter int PIN_W = DEF_PIN_W,
  parameter int WORDS = DEF_WORDS,
  parameter int CNT_W = 8,
  parameter int ID_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   write_en,
  input  logic [PIN_W-1:0]       pins,
  input  logic                   frame_done,
  output logic [0:PIN_W*WORDS-1] mem,
  output logic                   frame_valid,
  output logic [ID_W-1:0]        frame_id,
  output logic                   short_err,
  output logic                   overrun
);

  bank_state_e             st [2];
  logic [CNT_W-1:0]        cnt;
  logic                    nxt;
  logic                    pres;
  logic                    drop;
  logic [0:PIN_W*WORDS-1]  q [2];
  logic                    tgt_ok, wr, last, any_pres, rel;
  logic [1:0]              we;

  // nxt is always the fill target: it only advances when a frame completes,
  // which keeps the banks alternating and makes nxt the oldest FULL bank.
  assign tgt_ok   = st[nxt] == BANK_EMPTY || st[nxt] == BANK_FILLING;
  assign wr       = write_en && !drop && tgt_ok;
  assign last     = wr && cnt == CNT_W'(WORDS - 1);
  assign any_pres = st[0] == BANK_PRESENTED || st[1] == BANK_PRESENTED;
  assign rel      = frame_done && frame_valid;
  assign we       = {wr && nxt, wr && !nxt};
  assign mem      = pres ? q[1] : q[0];

  for (genvar i = 0; i < 2; i++) begin : g_bank
    frame_bank #(.PIN_W(PIN_W), .WORDS(WORDS), .CNT_W(CNT_W)) u_bank (
      .clk  (clk),
      .we   (we[i]),
      .addr (cnt),
      .wdata(pins),
      .q    (q[i])
    );
  end

  // Bank lifecycle, fill counter, present/release handshake and error flags.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      st[0]       <= BANK_EMPTY;
      st[1]       <= BANK_EMPTY;
      cnt         <= '0;
      nxt         <= 1'b0;
      pres        <= 1'b0;
      drop        <= 1'b0;
      frame_valid <= 1'b0;
      frame_id    <= '0;
      short_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      short_err <= 1'b0;
      if (rel) begin
        st[pres]    <= BANK_EMPTY;
        frame_valid <= 1'b0;
        frame_id    <= frame_id + 1'b1;
      end else if (!any_pres && st[nxt] == BANK_FULL) begin
        st[nxt]     <= BANK_PRESENTED;
        pres        <= nxt;
        frame_valid <= 1'b1;
      end else if (!any_pres && st[!nxt] == BANK_FULL) begin
        st[!nxt]    <= BANK_PRESENTED;
        pres        <= !nxt;
        frame_valid <= 1'b1;
      end
      if (write_en) begin
        if (wr) begin
          st[nxt] <= last ? BANK_FULL : BANK_FILLING;
          cnt     <= last ? '0 : cnt + 1'b1;
          if (last) nxt <= !nxt;
        end else begin
          drop    <= 1'b1;
          overrun <= 1'b1;
        end
      end else begin
        drop <= 1'b0;
        if (st[nxt] == BANK_FILLING) begin
          st[nxt]   <= BANK_EMPTY;
          cnt       <= '0;
          short_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_pingpong_loader.sv
// tb_frame_pingpong_loader: directed scenario tests for the ping-pong frame loader
module tb_frame_pingpong_loader;
  localparam int PW = 12;
  localparam int NW = 200;
  localparam int MW = cnn_io_pkg::MEM_W;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          write_en = 1'b0;
  logic [PW-1:0] pins = '0;
  logic          frame_done = 1'b0;
  logic [0:MW-1] mem;
  logic          frame_valid;
  logic [3:0]    frame_id;
  logic          short_err;
  logic          overrun;

  int total = 0;
  int bad = 0;

  frame_pingpong_loader dut (
    .clk(clk), .rst_b(rst_b), .write_en(write_en), .pins(pins), .frame_done(frame_done),
    .mem(mem), .frame_valid(frame_valid), .frame_id(frame_id), .short_err(short_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Word k of a frame: 0 = k, 1 = ~k, 2 = k ^ 0xAAA.
  function automatic logic [PW-1:0] wv(input int k, input int mode);
    logic [PW-1:0] v;
    v = PW'(k);
    return mode == 1 ? ~v : mode == 2 ? v ^ 12'hAAA : v;
  endfunction

  // Expected flat frame built bit by bit: pin0 (word MSB) at the lowest index.
  function automatic logic [0:MW-1] frame(input int mode);
    logic [0:MW-1] f;
    logic [PW-1:0] v;
    for (int k = 0; k < NW; k++) begin
      v = wv(k, mode);
      for (int b = 0; b < PW; b++) f[k*PW+b] = v[PW-1-b];
    end
    return f;
  endfunction

  function automatic int diff_word(input logic [0:MW-1] a, input logic [0:MW-1] b);
    for (int k = 0; k < NW; k++) if (a[k*PW +: PW] !== b[k*PW +: PW]) return k;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      write_en = 1'b1;
      pins = wv(k, mode);
      tick();
    end
    write_en = 1'b0;
  endtask

  task automatic do_reset();
    write_en = 1'b0;
    frame_done = 1'b0;
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    tick();
  endtask

  task automatic pulse_done();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    tick();
    total++;
    if ({frame_valid, frame_id, short_err, overrun} !== 7'd0) begin
      bad++;
      $display("FAIL reset_outputs: got fv=%b id=%0d se=%b ov=%b, want all 0",
               frame_valid, frame_id, short_err, overrun);
    end
    rst_b = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [0:MW-1] exp;
    int errs;
    int d;
    exp = frame(0);
    burst(NW, 0);
    total++;
    if (frame_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %b want 0", frame_valid); end
    tick();
    total++;
    if (frame_valid !== 1'b1) begin bad++; $display("FAIL single_latency: got %b want 1", frame_valid); end
    total++;
    if (frame_id !== 4'd0) begin bad++; $display("FAIL single_id: got %0d want 0", frame_id); end
    total++;
    if (short_err !== 1'b0) begin bad++; $display("FAIL single_no_short: got %b want 0", short_err); end
    total++;
    if (mem[0:11] !== 12'h000) begin bad++; $display("FAIL single_word0: got %h want 000", mem[0:11]); end
    total++;
    if (mem[2388:2399] !== 12'h0C7) begin bad++; $display("FAIL single_word199: got %h want 0c7", mem[2388:2399]); end
    total++;
    if ({mem[12], mem[23]} !== 2'b01) begin bad++; $display("FAIL single_pin_order: got %b want 01", {mem[12], mem[23]}); end
    total++;
    d = diff_word(mem, exp);
    if (mem !== exp) begin bad++; $display("FAIL single_frame: word %0d got %h want %h", d, mem[d*PW +: PW], exp[d*PW +: PW]); end
    errs = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (frame_valid !== 1'b1 || mem !== exp || frame_id !== 4'd0) errs++;
    end
    total++;
    if (errs !== 0) begin bad++; $display("FAIL single_stable: got %0d unstable cycles want 0", errs); end
  endtask

  task automatic test_pingpong();
    logic [0:MW-1] exp_a;
    logic [0:MW-1] exp_b;
    int d;
    exp_a = frame(0);
    exp_b = frame(1);
    do_reset();
    burst(NW, 0);
    burst(NW, 1);
    repeat (50) tick();
    total++;
    d = diff_word(mem, exp_a);
    if (frame_valid !== 1'b1 || mem !== exp_a) begin bad++; $display("FAIL pp_first_held: fv=%b word %0d", frame_valid, d); end
    pulse_done();
    total++;
    if (frame_valid !== 1'b0) begin bad++; $display("FAIL pp_gap: got fv=%b want 0", frame_valid); end
    tick();
    total++;
    if (frame_valid !== 1'b1) begin bad++; $display("FAIL pp_gap_len: got fv=%b want 1", frame_valid); end
    total++;
    if (frame_id !== 4'd1) begin bad++; $display("FAIL pp_id: got %0d want 1", frame_id); end
    total++;
    d = diff_word(mem, exp_b);
    if (mem !== exp_b) begin bad++; $display("FAIL pp_second_frame: word %0d got %h want %h", d, mem[d*PW +: PW], exp_b[d*PW +: PW]); end
  endtask

  task automatic test_overrun();
    logic [0:MW-1] exp_b;
    int d;
    exp_b = frame(1);
    do_reset();
    burst(NW, 0);
    burst(NW, 1);
    repeat (3) tick();
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_pre: got %b want 0", overrun); end
    burst(NW, 2);
    repeat (5) tick();
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
    pulse_done();
    tick();
    total++;
    d = diff_word(mem, exp_b);
    if (frame_valid !== 1'b1 || mem !== exp_b) begin bad++; $display("FAIL ovr_frame1_kept: fv=%b word %0d got %h want %h", frame_valid, d, mem[d*PW +: PW], exp_b[d*PW +: PW]); end
    total++;
    if (frame_id !== 4'd1) begin bad++; $display("FAIL ovr_id: got %0d want 1", frame_id); end
    repeat (10) tick();
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid();
    logic [0:MW-1] exp;
    int d;
    exp = frame(1);
    burst(73, 0);
    write_en = 1'b1;
    #2 rst_b = 1'b0;
    #1;
    total++;
    if ({frame_valid, frame_id, short_err, overrun} !== 7'd0) begin
      bad++;
      $display("FAIL rst_mid_async: got fv=%b id=%0d se=%b ov=%b, want all 0",
               frame_valid, frame_id, short_err, overrun);
    end
    write_en = 1'b0;
    tick();
    rst_b = 1'b1;
    tick();
    burst(NW, 1);
    tick();
    total++;
    d = diff_word(mem, exp);
    if (frame_valid !== 1'b1 || frame_id !== 4'd0 || mem !== exp) begin
      bad++;
      $display("FAIL rst_mid_refill: fv=%b id=%0d word %0d got %h want %h", frame_valid, frame_id, d, mem[d*PW +: PW], exp[d*PW +: PW]);
    end
  endtask

  task automatic test_short();
    logic [0:MW-1] exp;
    int d;
    exp = frame(0);
    do_reset();
    burst(120, 2);
    total++;
    if (short_err !== 1'b0) begin bad++; $display("FAIL short_early: got %b want 0", short_err); end
    tick();
    total++;
    if (short_err !== 1'b1) begin bad++; $display("FAIL short_pulse: got %b want 1", short_err); end
    tick();
    total++;
    if (short_err !== 1'b0 || frame_valid !== 1'b0) begin bad++; $display("FAIL short_single: se=%b fv=%b want 0 0", short_err, frame_valid); end
    pulse_done();
    burst(NW, 0);
    tick();
    total++;
    d = diff_word(mem, exp);
    if (frame_valid !== 1'b1 || frame_id !== 4'd0 || mem !== exp) begin
      bad++;
      $display("FAIL short_next_frame: fv=%b id=%0d word %0d got %h want %h", frame_valid, frame_id, d, mem[d*PW +: PW], exp[d*PW +: PW]);
    end
  endtask

  task automatic test_simultaneous();
    logic [0:MW-1] exp;
    int d;
    exp = frame(2);
    do_reset();
    burst(NW, 0);
    repeat (4) tick();
    burst(NW - 1, 2);
    write_en = 1'b1;
    pins = wv(NW - 1, 2);
    frame_done = 1'b1;
    tick();
    write_en = 1'b0;
    frame_done = 1'b0;
    total++;
    if (frame_valid !== 1'b0) begin bad++; $display("FAIL sim_gap: got fv=%b want 0", frame_valid); end
    tick();
    total++;
    if (frame_valid !== 1'b1 || frame_id !== 4'd1) begin bad++; $display("FAIL sim_present: fv=%b id=%0d want 1 1", frame_valid, frame_id); end
    total++;
    d = diff_word(mem, exp);
    if (mem !== exp) begin bad++; $display("FAIL sim_frame: word %0d got %h want %h", d, mem[d*PW +: PW], exp[d*PW +: PW]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pingpong();
    test_overrun();
    test_reset_mid();
    test_short();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_pingpong_loader.md
Name: frame_pingpong_loader

Overview:
- Parametrised successor to the single-bank pin-to-memory loader that feeds `CNN`.
- Packs `PIN_W`-bit pin words into `WORDS`-word frames, using two banks (ping-pong).
- One bank fills from the pins while the other is held stable on the flat `mem` bus for the CNN core.
- Adds an internal word counter (the external `count` input is gone), a frame valid/done handshake, short-frame abort and overrun detection.

Parameters:
- `PIN_W`, 12, bits per input word (pin count).
- `WORDS`, 200, words per frame.
- `CNT_W`, 8, width of the internal word counter; requires 2^`CNT_W` > `WORDS`.
- `ID_W`, 4, width of the frame sequence counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_b`  in  1  asynchronous, active-low reset.
- `write_en`  in  1  high while a frame burst is streaming; one word per cycle.
- `pins`  in  `PIN_W`  input word; `pins[PIN_W-1]` corresponds to legacy `pin0`.
- `frame_done`  in  1  one-cycle pulse from the consumer releasing the presented bank.
- `mem`  out  `PIN_W*WORDS`  flat frame, declared [0:`PIN_W*WORDS`-1]; word k at bits [k*`PIN_W` +: `PIN_W`], pin0 at the lowest index.
- `frame_valid`  out  1  `mem` holds a complete frame.
- `frame_id`  out  `ID_W`  sequence number of the presented frame.
- `short_err`  out  1  one-cycle pulse: a burst ended before `WORDS` words.
- `overrun`  out  1  sticky: a burst arrived with no bank free.

Behaviour:
- Reset (asynchronous, any time, including mid-fill or mid-present):
  - both banks EMPTY, word counter 0, `frame_valid`=0, `frame_id`=0, `short_err`=0, `overrun`=0.
  - `mem` contents are don't-care until the first `frame_valid`.
- Bank states: EMPTY -> FILLING -> FULL -> PRESENTED -> EMPTY.
- Fill:
  - On a cycle with `write_en`=1 and a bank EMPTY or FILLING, write `pins` to word[cnt] of that bank, then cnt++.
  - If both banks are EMPTY, bank 0 is chosen first; after that, banks alternate.
  - When the write with cnt=`WORDS`-1 occurs, the bank goes FULL and cnt returns to 0.
  - Any further words in the same burst start a new frame in the other bank if it is EMPTY; otherwise they count as overrun.
- Short frame: `write_en` falls while cnt is in 1..`WORDS`-1 -> bank returns to EMPTY, cnt=0, `short_err` pulses the next cycle.
- Overrun: `write_en`=1 while no bank is EMPTY/FILLING ->
  - `overrun` sets;
  - words are dropped until `write_en` is low for at least one cycle;
  - the frame in progress and already-FULL frames are unaffected.
- Present:
  - The oldest FULL bank becomes PRESENTED the cycle after it went FULL, provided no bank is PRESENTED.
  - `frame_valid` rises in that same cycle. Latency is 1 clock from the last word's write edge to `frame_valid`=1.
  - The `mem` mux selects the PRESENTED bank. `mem` is bit-stable while `frame_valid`=1; writes never target the PRESENTED bank.
- Release:
  - `frame_done` with `frame_valid`=1 -> bank EMPTY, `frame_valid`=0 next cycle, `frame_id` increments (wraps modulo 2^`ID_W`).
  - `frame_done` with `frame_valid`=0 is ignored.
- Back-to-back: if the other bank is FULL at release, it is presented after exactly one cycle of `frame_valid`=0. The guaranteed low cycle provides an edge for consumers.
- Simultaneous events:
  - `frame_done` and the last word of the other bank on the same edge: release happens and the new bank goes FULL. Present follows the next cycle, so the one-cycle gap still holds.
  - `frame_done` while the presented bank would be the fill target is impossible by construction.
  - `write_en` falling on the same edge as the final word is a complete frame, not a short one.
- Legacy compatibility: `PIN_W`=12, `WORDS`=200 gives a 2400-bit `mem`, matching the existing 300x8 bus.

Decomposition:
- Shared package `cnn_io_pkg`:
  - bank-state enum (EMPTY, FILLING, FULL, PRESENTED);
  - localparam `MEM_W` = `PIN_W*WORDS`;
  - the frame word-ordering helper function.
- Sub-module `frame_bank`: one word-addressed register bank with write enable, write address and flat output. Instantiate it twice; the controller FSM and `mem` mux live in the top.

Test Plan:
- Single frame: 200 words, word k = k[11:0], `frame_done` never pulsed -> `frame_valid`=1 exactly 1 cycle after the last write, `mem`[0:11]=0x000, `mem`[2388:2399]=0x0C7, `frame_id`=0, stable for 1000 cycles.
- Ping-pong: two back-to-back bursts (second frame word k = ~k), `frame_done` pulsed 50 cycles after the second completes -> `frame_valid` low for exactly 1 cycle, then high with the second frame's data and `frame_id`=1.
- Overrun: third burst while frames 0 and 1 are held unreleased -> `overrun`=1 and stays 1; after `frame_done`, `mem` shows frame 1, not frame 2 data.
- Short frame: `write_en` held for 120 words -> `short_err` single pulse, no `frame_valid`; next full burst is presented with `frame_id`=0.
- Reset mid-fill: `rst_b` low asynchronously at word 73 -> all outputs 0 immediately; next 200-word burst is presented correctly in bank 0.
- Simultaneous release/completion: `frame_done` on the same edge as the last word of the next frame -> 1 low cycle, then `frame_valid`=1 with the new frame and `frame_id` incremented.
